// File: rtl/mealy_collector_pkg.sv
// mealy_collector_pkg: shared output-FSM state codes and handshake polarity
package mealy_collector_pkg;
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_PUT = 2'b01, S_REL = 2'b10} state_t;
    localparam logic DAV_ACTIVE = 1'b0;
endpackage

// File: rtl/collector_fifo.sv
// collector_fifo: power-of-two FIFO with combinational head, occupancy count and full/empty flags
module collector_fifo #(
    parameter int M = 4,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [M-1:0]  din,
    input  logic          pop,
    output logic [M-1:0]  dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [M-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    always_ff @(posedge clock) begin
        if (reset) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // A push while full only happens alongside a pop, so the slot being read is the one refilled
    always_ff @(posedge clock)
        if (push) mem[wr] <= din;
    assign dout = mem[rd];
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/mealy_out_collector.sv
// mealy_out_collector: buffers Mealy output samples and delivers them over a 4-phase dav_/rfd handshake.
// Define CHANGE_ONLY_EN to forward only samples that differ from the previous valid one.
module mealy_out_collector
    import mealy_collector_pkg::*;
#(
    parameter int M = 4,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [M-1:0]  z,
    input  logic          z_valid,
    input  logic          rfd,
    output logic [M-1:0]  dato,
    output logic          dav_,
    output logic [AW:0]   count,
    output logic          ovf
);
    state_t state, state_n;
    logic push_req, push_ok, pop, full, empty;
    logic [M-1:0] dout;
`ifdef CHANGE_ONLY_EN
    logic [M-1:0] last;
    logic have_last;
    assign push_req = z_valid && (!have_last || z != last);
    // Tracks every valid sample, dropped or not, so repeats stay suppressed after an overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            last <= '0;
            have_last <= 1'b0;
        end else if (z_valid) begin
            last <= z;
            have_last <= 1'b1;
        end
    end
`else
    assign push_req = z_valid;
`endif
    assign pop = state == S_IDLE && !empty && rfd;
    assign push_ok = push_req && (!full || pop);
    collector_fifo #(.M(M), .DEPTH(DEPTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push_ok),
        .din(z),
        .pop(pop),
        .dout(dout),
        .count(count),
        .full(full),
        .empty(empty)
    );
    always_comb begin
        state_n = S_IDLE;
        case (state)
            S_IDLE:  state_n = pop ? S_PUT : S_IDLE;
            S_PUT:   state_n = rfd ? S_PUT : S_REL;
            S_REL:   state_n = rfd ? S_IDLE : S_REL;
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            dato <= '0;
            dav_ <= ~DAV_ACTIVE;
            ovf <= 1'b0;
        end else begin
            state <= state_n;
            if (pop) dato <= dout;
            dav_ <= (state_n == S_PUT) ? DAV_ACTIVE : ~DAV_ACTIVE;
            if (push_req && full && !pop) ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mealy_out_collector.sv
// tb_mealy_out_collector: directed self-checking bench for mealy_out_collector (M=4, DEPTH=4).
// Honours CHANGE_ONLY_EN when choosing expected delivery sequences.
module tb_mealy_out_collector;
    import mealy_collector_pkg::*;

    logic clock = 1'b0;
    logic reset, z_valid, rfd;
    logic [3:0] z, dato;
    logic dav_, ovf;
    logic [2:0] count;
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mealy_out_collector #(.M(4), .DEPTH(4)) dut (
        .clock(clock),
        .reset(reset),
        .z(z),
        .z_valid(z_valid),
        .rfd(rfd),
        .dato(dato),
        .dav_(dav_),
        .count(count),
        .ovf(ovf)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        z_valid = 1'b0;
        rfd = 1'b0;
        z = 4'h0;
        tick();
        reset = 1'b0;
    endtask

    task automatic read_word(output logic [3:0] d, output bit ok);
        int n;
        ok = 1'b0;
        d = 4'hx;
        n = 0;
        rfd = 1'b1;
        while (dav_ !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        if (dav_ === 1'b0) begin
            ok = 1'b1;
            d = dato;
            rfd = 1'b0;
            tick();
            rfd = 1'b1;
            tick();
        end
    endtask

    task automatic expect_word(input string name, input logic [3:0] exp);
        logic [3:0] d;
        bit ok;
        read_word(d, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: timeout waiting for dav_=0, required dato=%h", name, exp);
        end else if (d !== exp) begin
            errors++;
            $display("FAIL %s: dato=%h required %h", name, d, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (dav_ !== 1'b1) begin errors++; $display("FAIL reset_dav: got %b want 1", dav_); end
        if (dato !== 4'h0) begin errors++; $display("FAIL reset_dato: got %h want 0", dato); end
        if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        z = 4'hA;
        z_valid = 1'b1;
        rfd = 1'b1;
        tick();
        z_valid = 1'b0;
        tick();
        checks += 2;
        if (dav_ !== 1'b0) begin errors++; $display("FAIL midhs_dav: got %b want 0", dav_); end
        if (dut.state !== S_PUT) begin errors++; $display("FAIL midhs_state: got %0d want %0d", dut.state, S_PUT); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks += 3;
        if (dav_ !== 1'b1) begin errors++; $display("FAIL midrst_dav: got %b want 1", dav_); end
        if (count !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", count); end
        if (dut.state !== S_IDLE) begin errors++; $display("FAIL midrst_state: got %0d want %0d", dut.state, S_IDLE); end
    endtask

    task automatic test_latency();
        do_reset();
        rfd = 1'b1;
        z = 4'hA;
        z_valid = 1'b1;
        tick();
        z_valid = 1'b0;
        checks += 2;
        if (dav_ !== 1'b1) begin errors++; $display("FAIL lat_early_dav: got %b want 1", dav_); end
        if (count !== 3'd1) begin errors++; $display("FAIL lat_count1: got %0d want 1", count); end
        tick();
        checks += 3;
        if (dav_ !== 1'b0) begin errors++; $display("FAIL lat_dav: got %b want 0", dav_); end
        if (dato !== 4'hA) begin errors++; $display("FAIL lat_dato: got %h want a", dato); end
        if (count !== 3'd0) begin errors++; $display("FAIL lat_count0: got %0d want 0", count); end
        tick();
        checks++;
        if (dav_ !== 1'b0) begin errors++; $display("FAIL lat_hold_dav: got %b want 0", dav_); end
        rfd = 1'b0;
        tick();
        checks += 2;
        if (dav_ !== 1'b1) begin errors++; $display("FAIL lat_rel_dav: got %b want 1", dav_); end
        if (dut.state !== S_REL) begin errors++; $display("FAIL lat_rel_state: got %0d want %0d", dut.state, S_REL); end
        rfd = 1'b1;
        tick();
        checks++;
        if (dut.state !== S_IDLE) begin errors++; $display("FAIL lat_idle_state: got %0d want %0d", dut.state, S_IDLE); end
    endtask

    task automatic test_overflow();
        do_reset();
        z_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            z = 4'(i);
            tick();
            if (i == 4) begin
                checks += 2;
                if (count !== 3'd4) begin errors++; $display("FAIL ovf_fill_count: got %0d want 4", count); end
                if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b want 0", ovf); end
            end
        end
        z_valid = 1'b0;
        checks += 2;
        if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", count); end
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        expect_word("ovf_rd1", 4'h1);
        expect_word("ovf_rd2", 4'h2);
        expect_word("ovf_rd3", 4'h3);
        expect_word("ovf_rd4", 4'h4);
        checks += 2;
        if (count !== 3'd0) begin errors++; $display("FAIL ovf_drain_count: got %0d want 0", count); end
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        do_reset();
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    endtask

    task automatic test_full_pop();
        do_reset();
        z_valid = 1'b1;
        for (int i = 7; i <= 10; i++) begin
            z = 4'(i);
            tick();
        end
        z = 4'hB;
        rfd = 1'b1;
        tick();
        z_valid = 1'b0;
        checks += 4;
        if (count !== 3'd4) begin errors++; $display("FAIL fp_count: got %0d want 4", count); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL fp_ovf: got %b want 0", ovf); end
        if (dav_ !== 1'b0) begin errors++; $display("FAIL fp_dav: got %b want 0", dav_); end
        if (dato !== 4'h7) begin errors++; $display("FAIL fp_dato: got %h want 7", dato); end
        rfd = 1'b0;
        tick();
        expect_word("fp_rd8", 4'h8);
        expect_word("fp_rd9", 4'h9);
        expect_word("fp_rdA", 4'hA);
        expect_word("fp_rdB", 4'hB);
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL fp_end_count: got %0d want 0", count); end
    endtask

    task automatic test_change_only();
        logic [3:0] b1 [$];
        logic [3:0] b2 [$];
`ifdef CHANGE_ONLY_EN
        b1 = '{4'h3};
        b2 = '{4'h5, 4'h3};
`else
        b1 = '{4'h3, 4'h3, 4'h3};
        b2 = '{4'h5, 4'h5, 4'h3};
`endif
        do_reset();
        z_valid = 1'b1;
        z = 4'h3;
        tick();
        tick();
        tick();
        z_valid = 1'b0;
        checks++;
        if (count !== 3'(b1.size())) begin errors++; $display("FAIL co_count1: got %0d want %0d", count, b1.size()); end
        foreach (b1[i]) expect_word("co_batch1", b1[i]);
        z_valid = 1'b1;
        rfd = 1'b0;
        z = 4'h5;
        tick();
        tick();
        z = 4'h3;
        tick();
        z_valid = 1'b0;
        checks++;
        if (count !== 3'(b2.size())) begin errors++; $display("FAIL co_count2: got %0d want %0d", count, b2.size()); end
        foreach (b2[i]) expect_word("co_batch2", b2[i]);
        rfd = 1'b1;
        tick();
        tick();
        tick();
        checks += 2;
        if (dav_ !== 1'b1) begin errors++; $display("FAIL co_no_extra: dav_=%b want 1", dav_); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL co_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_wrap();
        do_reset();
        rfd = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            z = 4'(k);
            z_valid = 1'b1;
            tick();
            z_valid = 1'b0;
            expect_word("wrap_rd", 4'(k));
        end
        checks += 2;
        if (count !== 3'd0) begin errors++; $display("FAIL wrap_count: got %0d want 0", count); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b want 0", ovf); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_full_pop();
        test_change_only();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
